// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// The state encoding and counter sizing are used by the top-level FSM.
package div_pkg;

    localparam int DEFAULT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // The step counter must hold W-1. It is kept at least 1 bit wide so that W=1 stays legal.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_W);

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and keep the difference when it is non-negative.
module div_restoring_step #(
    parameter int W = 4
) (
    input  logic [W:0]   rem,
    input  logic         next_bit,
    input  logic [W-1:0] divisor,
    output logic [W:0]   new_rem,
    output logic         q_bit
);

    logic [W:0]   shifted;
    logic [W+1:0] trial;
    logic         take;

    always_comb begin
        shifted = {rem[W-1:0], next_bit};
        trial   = {1'b0, shifted} - {2'b0, divisor};
        // A set rem[W] means the true shifted value is at least 2^(W+1), which is
        // above any divisor. The low W+1 bits of the difference are still exact.
        take    = rem[W] | ~trial[W+1];
        q_bit   = take;
        new_rem = take ? trial[W:0] : shifted;
    end

endmodule

// File: rtl/div8by4_seq_restoring.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient
// and remainder, with divide-by-zero and quotient-overflow flags and a valid/ready handshake on both sides.
module div8by4_seq_restoring
    import div_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = cnt_width(W);

    state_e         state, state_next;
    logic [CW-1:0]  cnt;
    logic [W:0]     rem_q;
    logic [W-1:0]   q_sr;
    logic [W-1:0]   divisor_q;

    logic           accept;
    logic           zero_div;
    logic           quot_ovf;
    logic [W:0]     step_rem;
    logic           step_bit;

    assign accept   = (state == IDLE) && in_valid;
    assign zero_div = (divisor == '0);
    // The quotient fits in W bits exactly when the upper dividend half is below the divisor.
    assign quot_ovf = (dividend[2*W-1:W] >= divisor);

    div_restoring_step #(.W(W)) u_step (
        .rem      (rem_q),
        .next_bit (q_sr[W-1]),
        .divisor  (divisor_q),
        .new_rem  (step_rem),
        .q_bit    (step_bit)
    );

    // NOTE: every signal written in a combinational block gets a default first, so no latch can be inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (in_valid) state_next = (zero_div || quot_ovf) ? DONE : RUN;
            RUN:  if (cnt == '0) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem_q       <= '0;
            q_sr        <= '0;
            divisor_q   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        divisor_q   <= divisor;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        if (zero_div) begin
                            div_by_zero <= 1'b1;
                            q_sr        <= '1;
                            rem_q       <= {1'b0, dividend[W-1:0]};
                        end else if (quot_ovf) begin
                            overflow <= 1'b1;
                            q_sr     <= '1;
                            rem_q    <= '0;
                        end else begin
                            rem_q <= {1'b0, dividend[2*W-1:W]};
                            q_sr  <= dividend[W-1:0];
                            cnt   <= CW'(W - 1);
                        end
                    end
                end
                RUN: begin
                    rem_q <= step_rem;
                    q_sr  <= W'({q_sr, step_bit});
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign quotient  = q_sr;
    assign remainder = rem_q[W-1:0];

endmodule

// File: doc/div8by4_seq_restoring.md
Name: div8by4_seq_restoring

Overview:
- Sequential restoring divider; the inverse of the team's 4x4 multipliers.
- Takes a 2W-bit product-width dividend and a W-bit divisor and returns a W-bit quotient and W-bit remainder.
- Flags divide-by-zero and quotient overflow.
- Sits behind the multiplier arrays in the verification/datapath harness: feeding it P and B recovers A. It is also usable as a standalone divide unit.
- Valid/ready handshake on both sides.

Parameters:
- W, 4, operand width; dividend is 2W bits, quotient and remainder are W bits each.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  dividend/divisor valid
- in_ready  out  1  block can accept an operation
- dividend  in  2W  numerator, unsigned
- divisor  in  W  denominator, unsigned
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  W  result quotient
- remainder  out  W  result remainder
- div_by_zero  out  1  divisor was 0
- overflow  out  1  true quotient needed more than W bits

Behaviour:
- Reset, asynchronous on rst_n low, overrides everything:
  - state=IDLE, in_ready=1, out_valid=0.
  - quotient, remainder, div_by_zero and overflow all 0; internal counter 0.
- A reset mid-operation abandons the operation. No result is produced.
- All operands are unsigned.
- States: IDLE, RUN, DONE.
- in_ready=1 only in IDLE. out_valid=1 only in DONE. Outputs are registered.
- IDLE, accept (in_valid & in_ready at an edge): capture operands and evaluate special cases from the inputs.
  - divisor==0: go to DONE. div_by_zero=1, overflow=0, quotient=all ones, remainder=dividend[W-1:0]. Latency 1 edge.
  - Otherwise dividend[2W-1:W] >= divisor: go to DONE. overflow=1, div_by_zero=0, quotient=all ones, remainder=0. Latency 1 edge.
  - Otherwise: partial remainder (W+1 bits) = dividend[2W-1:W]; quotient shift register = dividend[W-1:0]; counter=W-1; go to RUN.
- RUN, one restoring step per edge:
  - trial = {rem[W-1:0], q_msb} - {0, divisor}.
  - If trial is non-negative: rem = trial, shifted-in quotient bit = 1.
  - Otherwise: rem = shifted value, bit = 0.
  - Quotient shifts left.
  - On the edge with counter==0, go to DONE. Otherwise decrement.
  - Exactly W RUN edges. The partial remainder never exceeds 2*divisor-1, so W+1 bits suffice.
- DONE:
  - Hold all outputs stable while out_valid & !out_ready (backpressure of any length).
  - On an edge with out_ready=1, go to IDLE. out_valid drops, and result registers keep their values.
- Latency, acceptance edge to out_valid high: W+1 edges for normal operations, 1 edge for special cases.
- Throughput: one operation per W+2 cycles minimum, since IDLE is always visited.
- in_valid while busy is ignored. Dividend and divisor must not be re-sampled outside IDLE.
- Result identity for normal operations: quotient*divisor + remainder == dividend, with remainder < divisor.
- Status flags are mutually exclusive and are cleared at the next acceptance.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, RUN, DONE}
  - default W constant
  - counter width localparam, $clog2(W)
- One natural sub-module: div_restoring_step.
  - Combinational, parameterized by W.
  - Inputs: rem (W+1 bits), next dividend bit, divisor.
  - Outputs: new rem, quotient bit.
  - Instantiated once and reused every RUN cycle.
- FSM, counter and handshake stay in the top module.

Test Plan:
- Exact division: dividend=143, divisor=13 (W=4) -> quotient=11, remainder=0, flags 0; out_valid high 5 edges after acceptance.
- Non-exact with max operands: dividend=224, divisor=15 -> quotient=14, remainder=14.
- Divide-by-zero: dividend=0x64, divisor=0 -> out_valid after 1 edge, div_by_zero=1, quotient=0xF, remainder=0x4.
- Overflow: dividend=200, divisor=10 (high nibble 12 >= 10) -> overflow=1, quotient=0xF, remainder=0, latency 1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 7 cycles in DONE -> outputs stable, in_ready=0, a new in_valid is ignored.
  - Release -> IDLE next edge; second operation 36/6 -> quotient=6, remainder=0.
- Reset mid-operation:
  - Assert rst_n=0 during the 2nd RUN cycle of 143/13 -> all outputs 0 immediately (asynchronous), in_ready=1 after release, no stale out_valid.
  - Exhaustive sweep of all 256x16 operand pairs checked against the quotient/remainder identity.
